// File: rtl/aes_encryptor.sv
// aes_encryptor: iterative AES-128 encryptor, one round per Clk, round keys fetched externally via SelKey.
// Optional AES_ENC_BUSY_EN adds a registered Busy output that is high while rounds are running.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] T = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  assign y = T[11'd2047 - {a, 3'b000} -: 8];
endmodule

module aes_encryptor (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         En,
  input  logic [127:0] Key,
  input  logic [127:0] PT,
  output logic [3:0]   SelKey,
  output logic         Ry,
  output logic [127:0] CT
`ifdef AES_ENC_BUSY_EN
  , output logic       Busy
`endif
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
  state_t st, st_n;
  logic [127:0] s, s_n, sb, sr, mc, ct_n;
  logic [3:0] sel_n;
  logic ry_n;
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  genvar i, r, c;
  for (i = 0; i < 16; i++) begin : g_sb
    aes_sbox u_sb (.a(s[127-8*i -: 8]), .y(sb[127-8*i -: 8]));
  end
  // row-major layout: row r, column c lives at byte 4r+c; ShiftRows rotates row r left by r
  for (r = 0; r < 4; r++) begin : g_sr
    for (c = 0; c < 4; c++) begin : g_col
      assign sr[127-8*(4*r+c) -: 8] = sb[127-8*(4*r+(c+r)%4) -: 8];
    end
  end
  for (c = 0; c < 4; c++) begin : g_mc
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr[127-8*c -: 8];
    assign a1 = sr[95-8*c -: 8];
    assign a2 = sr[63-8*c -: 8];
    assign a3 = sr[31-8*c -: 8];
    assign mc[127-8*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
    assign mc[95-8*c -: 8]  = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
    assign mc[63-8*c -: 8]  = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
    assign mc[31-8*c -: 8]  = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
  end
  always_comb begin
    st_n = st;
    s_n = s;
    sel_n = SelKey;
    ry_n = Ry;
    ct_n = CT;
    case (st)
      IDLE: if (En) begin
        s_n = PT ^ Key;
        sel_n = 4'd1;
        ry_n = 1'b0;
        st_n = ROUND;
      end
      ROUND: if (SelKey == 4'd10) begin
        ct_n = sr ^ Key;
        sel_n = 4'd0;
        ry_n = 1'b1;
        st_n = DONE;
      end else begin
        s_n = mc ^ Key;
        sel_n = SelKey + 4'd1;
      end
      DONE: st_n = En ? DONE : IDLE;
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      st <= IDLE;
      s <= '0;
      SelKey <= '0;
      Ry <= 1'b0;
      CT <= '0;
    end else begin
      st <= st_n;
      s <= s_n;
      SelKey <= sel_n;
      Ry <= ry_n;
      CT <= ct_n;
    end
  end
`ifdef AES_ENC_BUSY_EN
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) Busy <= 1'b0;
    else Busy <= st_n == ROUND;
  end
`endif
endmodule

// File: tb/tb_aes_encryptor.sv
// tb_aes_encryptor: scoreboard bench; reference AES model builds its S-box from GF(2^8) inverses and expands keys itself.
module tb_aes_encryptor;
  logic Clk, Rst, En;
  logic [127:0] Key, PT, CT;
  logic [3:0] SelKey;
  logic Ry;
`ifdef AES_ENC_BUSY_EN
  logic Busy;
`endif
  int checks = 0;
  int errors = 0;
  logic [127:0] q[$];
  logic [7:0] sbt [256];
  logic [127:0] rk [16];
  logic [127:0] rkc [11];
  localparam logic [127:0] APPB_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] APPB_PT = 128'h328831e0435a3137f6309807a88da234;
  localparam logic [127:0] APPB_CT = 128'h3902dc1925dc116a8409850b1dfb9732;

  aes_encryptor dut (
    .Clk(Clk), .Rst(Rst), .En(En), .Key(Key), .PT(PT),
    .SelKey(SelKey), .Ry(Ry), .CT(CT)
`ifdef AES_ENC_BUSY_EN
    , .Busy(Busy)
`endif
  );

  assign Key = rk[SelKey];

  initial begin
    Clk = 0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox;
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 0;
      for (int b = 1; b < 256; b++)
        if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbt[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  // FIPS column-major <-> port row-major is a plain byte transpose
  function automatic logic [127:0] tr(input logic [127:0] v);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(4*r+c) -: 8] = v[127-8*(4*c+r) -: 8];
    return o;
  endfunction

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbt[t[31:24]], sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) begin
      rkc[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      rk[r] = tr(rkc[r]);
    end
  endtask

  function automatic logic [127:0] enc(input logic [127:0] p);
    logic [127:0] s, t;
    logic [7:0] a0, a1, a2, a3;
    s = p ^ rkc[0];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int i = 0; i < 16; i++) t[127-8*i -: 8] = sbt[s[127-8*i -: 8]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          s[127-8*(4*c+r) -: 8] = t[127-8*(4*((c+r)%4)+r) -: 8];
      if (rd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
          a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
          t[127-32*c -: 8] = gm(a0, 2) ^ gm(a1, 3) ^ a2 ^ a3;
          t[119-32*c -: 8] = a0 ^ gm(a1, 2) ^ gm(a2, 3) ^ a3;
          t[111-32*c -: 8] = a0 ^ a1 ^ gm(a2, 2) ^ gm(a3, 3);
          t[103-32*c -: 8] = gm(a0, 3) ^ a1 ^ a2 ^ gm(a3, 2);
        end
        s = t;
      end
      s ^= rkc[rd];
    end
    return s;
  endfunction

  // one operation: SelKey sequence, latency and Busy are checked edge by edge; CT goes through the scoreboard
  task automatic run(input logic [127:0] pt, input logic [127:0] exp, input bit drop, input int hold);
    int nb = 0;
    @(negedge Clk) En = 0;
    @(negedge Clk) begin
      PT = pt;
      En = 1;
      q.push_back(exp);
    end
    for (int n = 1; n <= 11; n++) begin
      @(negedge Clk);
      PT = {$urandom, $urandom, $urandom, $urandom};
      if (drop) En = 0;
      chk($sformatf("selkey_edge%0d", n), 128'(SelKey), (n == 11) ? 128'd0 : 128'(n));
      chk($sformatf("ry_edge%0d", n), 128'(Ry), 128'(n == 11));
`ifdef AES_ENC_BUSY_EN
      nb += int'(Busy);
`endif
    end
`ifdef AES_ENC_BUSY_EN
    chk("busy_cycles", 128'(nb), 128'd10);
`endif
    for (int k = 0; k < hold; k++) begin
      @(negedge Clk);
      chk("hold_selkey", 128'(SelKey), 128'd0);
      chk("hold_ry", 128'(Ry), 128'd1);
    end
  endtask

  initial begin
    logic rq = 0;
    logic [127:0] last = 0;
    forever begin
      @(negedge Clk);
      if (Rst) rq = 0;
      else begin
        if (Ry && !rq) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ry: got Ry=1 expected no completion, CT=%h", CT);
          end else chk("ct", CT, q.pop_front());
        end else if (Ry && rq) chk("ct_hold", CT, last);
        rq = Ry;
        last = CT;
      end
    end
  end

  initial begin
    logic [127:0] key, pt;
    Rst = 1;
    En = 0;
    PT = '0;
    build_sbox();
    set_key(APPB_KEY);
    repeat (2) @(negedge Clk);
    chk("reset_selkey", 128'(SelKey), 128'd0);
    chk("reset_ry", 128'(Ry), 128'd0);
    chk("reset_ct", CT, 128'd0);
`ifdef AES_ENC_BUSY_EN
    chk("reset_busy", 128'(Busy), 128'd0);
`endif
    Rst = 0;
    run(APPB_PT, APPB_CT, 0, 40);
    run(APPB_PT, APPB_CT, 1, 0);
    @(negedge Clk) En = 0;
    @(negedge Clk) begin
      PT = APPB_PT;
      En = 1;
    end
    repeat (5) @(negedge Clk);
    chk("mid_selkey", 128'(SelKey), 128'd5);
    Rst = 1;
    #1;
    chk("abort_selkey", 128'(SelKey), 128'd0);
    chk("abort_ry", 128'(Ry), 128'd0);
    chk("abort_ct", CT, 128'd0);
`ifdef AES_ENC_BUSY_EN
    chk("abort_busy", 128'(Busy), 128'd0);
`endif
    @(negedge Clk) begin
      Rst = 0;
      En = 0;
    end
    run(APPB_PT, APPB_CT, 0, 2);
    for (int k = 0; k < 20; k++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt = {$urandom, $urandom, $urandom, $urandom};
      @(negedge Clk) En = 0;
      set_key(key);
      run(pt, tr(enc(tr(pt))), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end
    repeat (3) @(negedge Clk);
    chk("queue_empty", 128'(q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/aes_encryptor.md
AES_ENCRYPTOR -- requirements
Module: aes_encryptor

Interface
REQ-001 The block SHALL have these ports: Clk  in  1  sole clock, all state updates on its rising edge.
REQ-002 Rst  in  1  asynchronous, active-high reset.
REQ-003 En  in  1  level start request.
REQ-004 Key  in  128  round key selected by SelKey, driven combinationally by the external key store in the same cycle.
REQ-005 PT  in  128  plaintext block, sampled only on the start edge.
REQ-006 SelKey  out  4  registered round-key index, 0..10.
REQ-007 Ry  out  1  registered completion flag.
REQ-008 CT  out  128  registered ciphertext.
REQ-009 Busy  out  1  present only with AES_ENC_BUSY_EN (REQ-027).

Function
REQ-010 The block SHALL implement AES-128 encryption per FIPS-197, one round per clock, with round keys supplied externally and no on-chip key expansion.
REQ-011 State, PT, CT and Key SHALL use row-major byte layout: byte at bits [127-8k:120-8k] is state row k/4, column k%4.
REQ-012 FSM states SHALL be IDLE, ROUND and DONE; the reset state is IDLE.
REQ-013 IDLE with En=1 at a rising edge (start edge): state <= PT xor Key (SelKey=0), SelKey <= 1, Ry <= 0, go to ROUND.
REQ-014 ROUND with SelKey in 1..9: state <= MixColumns(ShiftRows(SubBytes(state))) xor Key, SelKey <= SelKey+1.
REQ-015 ROUND with SelKey=10: CT <= ShiftRows(SubBytes(state)) xor Key, with MixColumns omitted; SelKey <= 0, Ry <= 1, go to DONE.
REQ-016 DONE SHALL go to IDLE when En=0 is sampled and SHALL stay in DONE while En=1, so a held En yields exactly one operation.
REQ-017 Latency SHALL be fixed: Ry rises on the 11th rising edge counting the start edge as the 1st.
REQ-018 Ry SHALL remain high, and CT SHALL hold its value, from completion until the next start edge; Ry clears on the start edge, and CT changes only at completion.
REQ-019 En deassertion during ROUND SHALL be ignored, and the operation SHALL complete normally.
REQ-020 PT changes after the start edge SHALL not affect the result.
REQ-021 SelKey SHALL be 0 in IDLE and DONE, so the external Key presents round key 0 before any start.
REQ-022 SubBytes SHALL use 16 instances of the team's existing byte S-box module; MixColumns SHALL use xtime (GF(2^8), polynomial 0x11B).

Reset
REQ-023 Rst=1 SHALL immediately force: FSM to IDLE, SelKey 0, Ry 0, CT all zeros, internal state zero, and Busy 0 if present.
REQ-024 Rst asserted mid-operation SHALL abort the operation with no partial CT update.
REQ-025 After Rst is released, the block SHALL accept a start on the first rising edge with En=1.

Configuration
REQ-026 Macro AES_ENC_BUSY_EN SHALL control the Busy feature.
REQ-027 With AES_ENC_BUSY_EN defined: Busy is a registered output, high from the start edge through the edge that sets Ry, i.e. high exactly while the FSM is in ROUND.
REQ-028 Without AES_ENC_BUSY_EN: the Busy port and its logic are absent, and all other behaviour is identical.

Verification
REQ-029 FIPS-197 App. B vector, row-major: PT=328831e0435a3137f6309807a88da234, SelKey 0..10 keys 2b28ab09..., a088232a..., ..., d0c9e1b6... -> Ry after 11 edges, CT=3902dc1925dc116a8409850b1dfb9732.
REQ-030 Log SelKey per cycle -> sequence 0,1,2,...,10,0 on consecutive edges from the start edge, with no gaps or repeats.
REQ-031 Hold En=1 for 40 cycles after Ry -> no second operation, SelKey stays 0, CT stable; drop En, then raise it -> second run, same CT.
REQ-032 Assert Rst for 1 cycle when SelKey=5 -> SelKey=0, Ry=0, CT=0 immediately; a following start gives the App. B CT.
REQ-033 Loopback: feed CT into AES_Decryptor with the same key store -> its PT equals the original PT.
REQ-034 AES_ENC_BUSY_EN defined -> Busy high for exactly 10 cycles per operation and 0 after reset; undefined -> compiles with no Busy port.
